// File: rtl/reg_status_table_pkg.sv
// Shared out-of-order core types: ROB tag, architectural register address and data widths.
package ooo_pkg;
    localparam int TAG_W      = 5;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    // Resolved operand: either a ready value or the ROB tag to wait on.
    typedef struct packed {
        logic  ready;
        data_t val;
        tag_t  tag;
    } src_res_t;
endpackage

// File: rtl/reg_status_table_if.sv
// Issue/lookup and commit bundle between the front end, the rename table and the ROB.
interface reg_status_table_if;
    import ooo_pkg::*;

    logic      issue_valid;
    logic      rob_full;
    tag_t      issue_tag;
    reg_addr_t dest_reg;
    reg_addr_t src1_reg;
    reg_addr_t src2_reg;
    logic      src1_ready;
    data_t     src1_val;
    tag_t      src1_tag;
    logic      src2_ready;
    data_t     src2_val;
    tag_t      src2_tag;
    logic      issue_accept;
    logic      commit_valid;
    tag_t      commit_tag;
    reg_addr_t commit_addr;
    data_t     commit_val;
    logic      flush;

    modport master (
        output issue_valid, rob_full, issue_tag, dest_reg, src1_reg, src2_reg,
        output commit_valid, commit_tag, commit_addr, commit_val, flush,
        input  src1_ready, src1_val, src1_tag, src2_ready, src2_val, src2_tag, issue_accept
    );

    modport slave (
        input  issue_valid, rob_full, issue_tag, dest_reg, src1_reg, src2_reg,
        input  commit_valid, commit_tag, commit_addr, commit_val, flush,
        output src1_ready, src1_val, src1_tag, src2_ready, src2_val, src2_tag, issue_accept
    );
endinterface

// File: rtl/reg_status_table_regfile.sv
// Architectural register file: one synchronous write port, two asynchronous read ports, r0 reads zero.
module arch_regfile
    import ooo_pkg::*;
#(
    parameter int NUM_REGS = ooo_pkg::NUM_REGS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  data_t     wdata,
    input  reg_addr_t raddr1,
    output data_t     rdata1,
    input  reg_addr_t raddr2,
    output data_t     rdata2
);
    data_t mem [NUM_REGS];

    assign mem[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            localparam reg_addr_t ADDR = reg_addr_t'(gi);
            data_t val_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    val_reg <= '0;
                end else if (we && (waddr == ADDR)) begin
                    val_reg <= wdata;
                end
            end

            assign mem[gi] = val_reg;
        end
    endgenerate

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
endmodule

// File: rtl/reg_status_table.sv
// Rename / operand-fetch stage: per-register busy bit and newest producer tag, with commit bypass.
module reg_status_table
    import ooo_pkg::*;
#(
    parameter int NUM_REGS = ooo_pkg::NUM_REGS
) (
    input logic               clk,
    input logic               rst,
    reg_status_table_if.slave bus
);
    logic     busy [NUM_REGS];
    tag_t     tag  [NUM_REGS];
    data_t    rd1;
    data_t    rd2;
    logic     accept;
    logic     commit_we;
    src_res_t res1;
    src_res_t res2;

    assign accept    = bus.issue_valid & ~bus.rob_full & ~bus.flush;
    assign commit_we = bus.commit_valid & (bus.commit_addr != '0);

    arch_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (commit_we),
        .waddr  (bus.commit_addr),
        .wdata  (bus.commit_val),
        .raddr1 (bus.src1_reg),
        .rdata1 (rd1),
        .raddr2 (bus.src2_reg),
        .rdata2 (rd2)
    );

    assign busy[0] = 1'b0;
    assign tag[0]  = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_status
            localparam reg_addr_t ADDR = reg_addr_t'(gi);
            logic busy_reg;
            tag_t tag_reg;

            // A rename always beats a same-cycle commit; a commit only clears its own producer.
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_reg <= 1'b0;
                    tag_reg  <= '0;
                end else if (bus.flush) begin
                    busy_reg <= 1'b0;
                end else if (accept && (bus.dest_reg == ADDR)) begin
                    busy_reg <= 1'b1;
                    tag_reg  <= bus.issue_tag;
                end else if (commit_we && (bus.commit_addr == ADDR) && (tag_reg == bus.commit_tag)) begin
                    busy_reg <= 1'b0;
                end
            end

            assign busy[gi] = busy_reg;
            assign tag[gi]  = tag_reg;
        end
    endgenerate

    function automatic src_res_t resolve(reg_addr_t src, logic busy_s, tag_t tag_s, data_t rf_s);
        src_res_t r;
        r.ready = 1'b1;
        r.val   = rf_s;
        r.tag   = '0;
        if (src == '0) begin
            r.val = '0;
        end else if (bus.commit_valid && (bus.commit_addr == src) && (bus.commit_tag == tag_s) && busy_s) begin
            r.val = bus.commit_val;
        end else if (busy_s) begin
            r.ready = 1'b0;
            r.val   = '0;
            r.tag   = tag_s;
        end
        return r;
    endfunction

    always_comb begin
        res1 = resolve(bus.src1_reg, busy[bus.src1_reg], tag[bus.src1_reg], rd1);
        res2 = resolve(bus.src2_reg, busy[bus.src2_reg], tag[bus.src2_reg], rd2);
    end

    assign bus.src1_ready   = res1.ready;
    assign bus.src1_val     = res1.val;
    assign bus.src1_tag     = res1.tag;
    assign bus.src2_ready   = res2.ready;
    assign bus.src2_val     = res2.val;
    assign bus.src2_tag     = res2.tag;
    assign bus.issue_accept = accept;
endmodule

// File: tb/tb_reg_status_table.sv
// Directed scenarios plus randomized traffic checked against an array-based rename table model.
module tb_reg_status_table;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   txn;

    reg_status_table_if bus ();

    reg_status_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    logic [4:0]  m_tag  [32];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid  = 1'b0;
        bus.rob_full     = 1'b0;
        bus.issue_tag    = '0;
        bus.dest_reg     = '0;
        bus.src1_reg     = '0;
        bus.src2_reg     = '0;
        bus.commit_valid = 1'b0;
        bus.commit_tag   = '0;
        bus.commit_addr  = '0;
        bus.commit_val   = '0;
        bus.flush        = 1'b0;
        rst              = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Expected operand from the table contents as they stand before this cycle's edge.
    task automatic expect_src(input string name, input logic [4:0] s,
                              input logic rdy, input logic [31:0] val, input logic [4:0] tg);
        logic e_rdy;
        logic [31:0] e_val;
        logic [4:0] e_tag;
        e_rdy = 1'b1;
        e_val = m_reg[s];
        e_tag = '0;
        if (s == 0) begin
            e_val = '0;
        end else if (m_busy[s]) begin
            if (bus.commit_valid && bus.commit_addr == s && bus.commit_tag == m_tag[s]) begin
                e_val = bus.commit_val;
            end else begin
                e_rdy = 1'b0;
                e_val = '0;
                e_tag = m_tag[s];
            end
        end
        chk({name, "_ready"}, rdy, e_rdy);
        chk({name, "_val"}, val, e_val);
        chk({name, "_tag"}, tg, e_tag);
    endtask

    task automatic settle();
        #3;
        expect_src("src1", bus.src1_reg, bus.src1_ready, bus.src1_val, bus.src1_tag);
        expect_src("src2", bus.src2_reg, bus.src2_ready, bus.src2_val, bus.src2_tag);
        chk("accept", bus.issue_accept, bus.issue_valid & ~bus.rob_full & ~bus.flush);
    endtask

    task automatic tick();
        logic acc;
        acc = bus.issue_valid & ~bus.rob_full & ~bus.flush;
        @(posedge clk);
        txn++;
        $display("txn %0d rst=%0b iv=%0b full=%0b dest=%0d itag=%0d cv=%0b caddr=%0d ctag=%0d cval=%0h flush=%0b",
                 txn, rst, bus.issue_valid, bus.rob_full, bus.dest_reg, bus.issue_tag,
                 bus.commit_valid, bus.commit_addr, bus.commit_tag, bus.commit_val, bus.flush);
        if (rst) begin
            model_reset();
        end else begin
            if (bus.commit_valid && bus.commit_addr != 0) begin
                m_reg[bus.commit_addr] = bus.commit_val;
                if (m_tag[bus.commit_addr] == bus.commit_tag) m_busy[bus.commit_addr] = 1'b0;
            end
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (acc && bus.dest_reg != 0) begin
                m_busy[bus.dest_reg] = 1'b1;
                m_tag[bus.dest_reg]  = bus.issue_tag;
            end
        end
        #1;
    endtask

    task automatic issue(input logic [4:0] d, input logic [4:0] t);
        idle();
        bus.issue_valid = 1'b1;
        bus.dest_reg    = d;
        bus.issue_tag   = t;
        settle();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        txn      = 0;
        idle();
        rst = 1'b1;
        model_reset();
        tick();

        // 1: post-reset lookup
        idle();
        bus.src1_reg = 5'd5;
        settle();
        chk("t1_src1_ready", bus.src1_ready, 1'b1);
        chk("t1_src2_val", bus.src2_val, 32'h0);
        tick();

        // 2: rename then commit with same-cycle bypass
        issue(5'd3, 5'd7);
        idle();
        bus.src1_reg = 5'd3;
        settle();
        chk("t2_busy_ready", bus.src1_ready, 1'b0);
        chk("t2_busy_tag", bus.src1_tag, 5'd7);
        tick();
        idle();
        bus.src1_reg = 5'd3;
        bus.commit_valid = 1'b1;
        bus.commit_tag = 5'd7;
        bus.commit_addr = 5'd3;
        bus.commit_val = 32'hABCD;
        settle();
        chk("t2_bypass_ready", bus.src1_ready, 1'b1);
        chk("t2_bypass_val", bus.src1_val, 32'hABCD);
        tick();
        idle();
        bus.src1_reg = 5'd3;
        settle();
        chk("t2_retired_val", bus.src1_val, 32'hABCD);
        tick();

        // 3: older commit must not clear a younger rename
        issue(5'd4, 5'd2);
        issue(5'd4, 5'd9);
        idle();
        bus.src1_reg = 5'd4;
        bus.commit_valid = 1'b1;
        bus.commit_tag = 5'd2;
        bus.commit_addr = 5'd4;
        bus.commit_val = 32'h11;
        settle();
        chk("t3_young_ready", bus.src1_ready, 1'b0);
        tick();
        idle();
        bus.src2_reg = 5'd4;
        settle();
        chk("t3_young_tag", bus.src2_tag, 5'd9);
        tick();

        // 4: commit and rename to the same register in one cycle
        issue(5'd6, 5'd5);
        idle();
        bus.issue_valid = 1'b1;
        bus.dest_reg = 5'd6;
        bus.issue_tag = 5'd12;
        bus.commit_valid = 1'b1;
        bus.commit_tag = 5'd5;
        bus.commit_addr = 5'd6;
        bus.commit_val = 32'h66;
        settle();
        tick();
        idle();
        bus.src1_reg = 5'd6;
        settle();
        chk("t4_rename_wins", bus.src1_tag, 5'd12);
        tick();
        idle();
        bus.flush = 1'b1;
        settle();
        tick();
        idle();
        bus.src1_reg = 5'd6;
        bus.src2_reg = 5'd4;
        settle();
        chk("t4_reg6_val", bus.src1_val, 32'h66);
        chk("t3_reg4_val", bus.src2_val, 32'h11);
        tick();

        // 5: r0 is never renamed or written
        issue(5'd0, 5'd3);
        idle();
        bus.commit_valid = 1'b1;
        bus.commit_addr = 5'd0;
        bus.commit_val = 32'hFF;
        settle();
        tick();
        idle();
        settle();
        chk("t5_r0_val", bus.src1_val, 32'h0);
        chk("t5_r0_ready", bus.src1_ready, 1'b1);
        tick();

        // 6: flush with rob_full and issue_valid, then reset mid-sequence
        issue(5'd1, 5'd1);
        issue(5'd2, 5'd2);
        issue(5'd3, 5'd3);
        idle();
        bus.flush = 1'b1;
        bus.rob_full = 1'b1;
        bus.issue_valid = 1'b1;
        bus.dest_reg = 5'd5;
        bus.issue_tag = 5'd8;
        bus.src1_reg = 5'd3;
        settle();
        chk("t6_accept", bus.issue_accept, 1'b0);
        chk("t6_same_cycle_busy", bus.src1_ready, 1'b0);
        tick();
        idle();
        bus.src1_reg = 5'd3;
        bus.src2_reg = 5'd5;
        settle();
        chk("t6_flushed_val", bus.src1_val, 32'hABCD);
        chk("t6_no_rename", bus.src2_ready, 1'b1);
        tick();
        issue(5'd7, 5'd4);
        idle();
        rst = 1'b1;
        bus.commit_valid = 1'b1;
        bus.commit_addr = 5'd8;
        bus.commit_tag = 5'd1;
        bus.commit_val = 32'h5;
        bus.issue_valid = 1'b1;
        bus.dest_reg = 5'd9;
        tick();
        idle();
        bus.src1_reg = 5'd3;
        bus.src2_reg = 5'd7;
        settle();
        chk("t6_rst_val", bus.src1_val, 32'h0);
        chk("t6_rst_ready", bus.src2_ready, 1'b1);
        tick();

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ca;
            idle();
            rst              = ($urandom_range(0, 63) == 0);
            bus.flush        = ($urandom_range(0, 15) == 0);
            bus.rob_full     = ($urandom_range(0, 3) == 0);
            bus.issue_valid  = $urandom_range(0, 1);
            bus.dest_reg     = 5'($urandom_range(0, 7));
            bus.issue_tag    = 5'($urandom);
            bus.src1_reg     = 5'($urandom_range(0, 7));
            bus.src2_reg     = 5'($urandom_range(0, 7));
            bus.commit_valid = $urandom_range(0, 1);
            ca               = 5'($urandom_range(0, 7));
            bus.commit_addr  = ca;
            bus.commit_tag   = ($urandom_range(0, 1) == 1) ? m_tag[ca] : 5'($urandom);
            bus.commit_val   = $urandom;
            if ($urandom_range(0, 1) == 1) bus.src1_reg = ca;
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
